// File: rtl/itof_arbiter.sv
// itof_arbiter: shares one combinational int32 -> IEEE-754 single converter
// between NREQ requesters.
// Grants are round-robin. The datapath has an operand register followed by a
// result register, with a valid/ready handshake on both sides.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   req_valid[NREQ]      requester i presents an operand
//   req_data[32*NREQ]    operand i at [32*i +: 32], signed int32
//   req_ready[NREQ]      one-hot (or zero) grant, combinational
//   res_valid/res_ready  result handshake
//   res_data[32]         float result (round to nearest even)
//   res_id[IDW]          index of the requester that produced res_data
module itof_arbiter #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [31:0]          res_data,
   output logic [IDW-1:0]       res_id
);

   localparam int unsigned DW = 32;

   logic           s1_valid;
   logic [DW-1:0]  s1_data;
   logic [IDW-1:0] s1_id;
   logic [IDW-1:0] rr_ptr;

   logic           s2_free;
   logic           s1_adv;
   logic           s1_free;
   logic           grant_any;
   logic [IDW-1:0] grant_id;
   logic           take;
   logic [DW-1:0]  sel_data;
   logic [IDW-1:0] rr_next;
   logic [DW-1:0]  itof_res;

   // Pipeline flow control
   always_comb begin
      s2_free = !res_valid || res_ready;
      s1_adv  = s1_valid && s2_free;
      s1_free = !s1_valid || s1_adv;
   end

   // Round-robin search starting at rr_ptr. The loop walks downwards so that
   // the lowest offset from rr_ptr is the one that wins.
   always_comb begin
      int idx;
      grant_any = 1'b0;
      grant_id  = '0;
      idx       = 0;
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
         if (req_valid[IDW'(idx)]) begin
            grant_any = 1'b1;
            grant_id  = IDW'(idx);
         end
      end
   end

   // Grant qualification, operand select and pointer advance
   always_comb begin
      take     = s1_free && grant_any;
      sel_data = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         if (IDW'(k) == grant_id) sel_data = req_data[k*DW +: DW];
      end
      if (int'(grant_id) == int'(NREQ) - 1) rr_next = '0;
      else                                  rr_next = grant_id + IDW'(1);
      // No grant may be seen while reset is asserted.
      req_ready = (rstn && take) ? (NREQ'(1) << grant_id) : '0;
   end

   // int32 -> float: take the magnitude, normalise it, then round to nearest
   // even. A rounding carry ripples from the mantissa into the exponent.
   always_comb begin
      logic          sgn;
      logic [DW-1:0] mag;
      logic [DW-1:0] norm;
      logic [5:0]    lz;
      logic          rnd;
      logic [30:0]   exp_man;
      sgn  = s1_data[31];
      mag  = sgn ? DW'(-s1_data) : s1_data;
      lz   = '0;
      for (int b = 0; b < int'(DW); b++) begin
         if (mag[b]) lz = 6'(31 - b);
      end
      norm    = mag << lz;
      rnd     = norm[7] && ((|norm[6:0]) || norm[8]);
      exp_man = {8'd158 - {2'b00, lz}, norm[30:8]};
      exp_man = exp_man + 31'(rnd);
      itof_res = (mag == '0) ? '0 : {sgn, exp_man};
   end

   // Operand stage and round-robin pointer
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_id    <= '0;
         rr_ptr   <= '0;
      end else begin
         if (take) begin
            s1_valid <= 1'b1;
            s1_data  <= sel_data;
            s1_id    <= grant_id;
            rr_ptr   <= rr_next;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Result stage; data and id hold their value after a pop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
      end else begin
         if (s1_adv) begin
            res_valid <= 1'b1;
            res_data  <= itof_res;
            res_id    <= s1_id;
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule
